icache_direct_mapped: RTL
=========================

Name: icache_direct_mapped

Overview:
Blocking, direct-mapped, read-only instruction cache between the core's icache cmd/rsp port and a 64-bit line-refill memory port. Hits return one 32-bit instruction word in 1 cycle, matching the core's existing fetch timing. Misses fetch a full line as in-order 64-bit beats, install it, then answer. Flush input supports fence.i.

Parameters:
LINE_BYTES, 32, bytes per line; power of 2, >= 8; beats per line = LINE_BYTES/8
SETS, 64, number of lines; power of 2
ADDR_W, 64, address width

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
icache_flush  in  1  one-cycle pulse; invalidate all lines
icache_cmd_valid  in  1  fetch request
icache_cmd_ready  out  1  request accepted when valid&&ready
icache_cmd_payload_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
icache_rsp_valid  out  1  response strobe, one cycle, no backpressure
icache_rsp_payload_data  out  32  instruction word
mem_cmd_valid  out  1  line refill request
mem_cmd_ready  in  1  memory accepts request
mem_cmd_payload_addr  out  ADDR_W  line-aligned address (low log2(LINE_BYTES) bits zero)
mem_rsp_valid  in  1  refill beat strobe
mem_rsp_payload_data  in  64  refill beat, beats in ascending address order

Behaviour:
- Address split: offset=[log2(LINE_BYTES)-1:0], beat=offset[..:3], word=addr[2] (1 selects [63:32]), index=next log2(SETS) bits, tag=remaining upper bits.
- Storage: data, tag and valid arrays in flops. Only valid bits are reset.
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESPOND.
- IDLE: icache_cmd_ready=1. On accept, register the address and go to LOOKUP.
- LOOKUP, hit (valid[index] && tag match):
  - icache_rsp_valid=1 in this cycle, i.e. 1 cycle after accept.
  - icache_cmd_ready=1, so back-to-back hits sustain 1 fetch/cycle.
  - A new accept stays in LOOKUP; otherwise go to IDLE.
- LOOKUP, miss: icache_cmd_ready=0, go to REFILL_REQ.
- REFILL_REQ: mem_cmd_valid=1, payload held stable until mem_cmd_ready. On handshake go to REFILL_DATA with beat counter=0.
- REFILL_DATA:
  - Each mem_rsp_valid writes data[index][beat counter] and increments the counter.
  - On the last beat, write tag, set valid (unless a flush occurred during the refill), go to RESPOND.
- RESPOND: icache_rsp_valid=1 with the requested word from the new line, then go to IDLE. icache_cmd_ready=0 in this state.
- Miss latency: rsp 1 cycle after the last beat.
- Response rules:
  - Exactly one rsp per accepted cmd, in order.
  - icache_rsp_payload_data is don't-care when icache_rsp_valid=0.
  - rsp_valid is never asserted outside LOOKUP-hit or RESPOND.
- Flush:
  - In IDLE or LOOKUP: all valid bits cleared next cycle. A LOOKUP in the same cycle as flush still uses pre-flush contents.
  - During REFILL_REQ/REFILL_DATA/RESPOND: the refill completes and its response is delivered, but the line is not marked valid. Other lines are cleared immediately.
- mem_rsp_valid outside REFILL_DATA is ignored.
- Reset (including mid-refill):
  - state=IDLE, beat counter=0, all valid=0, flush-pending=0.
  - icache_rsp_valid=0, mem_cmd_valid=0, icache_cmd_ready=0 during reset, then 1 from the first cycle after reset.
  - The memory side shares this reset, so no stale beats follow.
- Same-index conflict: the new line overwrites the old one.

Optional Feature:
ICACHE_PERF_CNT_EN:
- Defined: adds outputs perf_hit_cnt and perf_miss_cnt, 32 bits each, reset to 0, wrap at 2^32.
  - hit increments on each LOOKUP hit.
  - miss increments on each LOOKUP miss.
  - Flush does not clear them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold miss: after reset, fetch 0x8000_0004; memory beats 0x1111_1111_0000_0000, then 3 more -> one mem_cmd addr 0x8000_0000; rsp data 0x1111_1111, 1 cycle after the 4th beat.
- Hit streaming: fetches 0x8000_0000, 0x8000_0008, 0x8000_000C on consecutive cycles after the fill -> 3 rsps on 3 consecutive cycles, no mem_cmd, data matches beats 0/1.
- Conflict eviction: fetch 0x8000_0800 (same index, SETS=64, LINE=32) -> miss, refill 0x8000_0800; a following fetch of 0x8000_0000 misses again.
- Flush: fill 0x8000_0000, pulse icache_flush, fetch 0x8000_0000 -> miss and refill. A flush pulsed mid-REFILL_DATA -> rsp delivered, next fetch of the same line misses.
- Memory backpressure: mem_cmd_ready low for 10 cycles -> mem_cmd_valid/addr stable for those cycles, icache_cmd_ready=0 throughout; completes normally once ready.
- Reset mid-refill: assert reset after the 2nd beat -> no rsp; all outputs at reset values; the next fetch to the same line misses and refills cleanly.

Source files
------------

// File: rtl/icache_direct_mapped.sv
// Blocking direct-mapped read-only I-cache: hit answers 1 cycle after accept, miss 1 cycle after last 64-bit refill beat; cmd_ready drops while a miss is in flight.
// Optional hit/miss counters via ICACHE_PERF_CNT_EN; mem_cmd is held stable until mem_cmd_ready, responses have no backpressure.
module icache_direct_mapped #(
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 64,
  parameter int ADDR_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_flush,
  input  logic              icache_cmd_valid,
  output logic              icache_cmd_ready,
  input  logic [ADDR_W-1:0] icache_cmd_payload_addr,
  output logic              icache_rsp_valid,
  output logic [31:0]       icache_rsp_payload_data,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_payload_addr,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rsp_payload_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_hit_cnt,
  output logic [31:0]       perf_miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int BEATS  = LINE_BYTES / 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESPOND} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q;
  logic [BEAT_W-1:0] beat_q;
  logic              flush_pend_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [63:0]       data_q [SETS][BEATS];

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [BEAT_W-1:0] req_beat;
  logic [63:0]       line_beat;
  logic              hit, last_beat, cmd_fire, beat_fire;

  assign req_off   = req_addr_q[OFF_W-1:0];
  assign req_idx   = req_addr_q[OFF_W +: IDX_W];
  assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_beat  = BEAT_W'(req_off >> 3);
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign cmd_fire  = icache_cmd_valid && icache_cmd_ready;
  assign beat_fire = (state_q == REFILL_DATA) && mem_rsp_valid;

  // Hit and RESPOND both read the array; the refilled line lands there on its last beat.
  assign line_beat               = data_q[req_idx][req_beat];
  assign icache_rsp_payload_data = req_addr_q[2] ? line_beat[63:32] : line_beat[31:0];
  assign mem_cmd_payload_addr    = {req_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    state_d          = state_q;
    icache_cmd_ready = 1'b0;
    icache_rsp_valid = 1'b0;
    mem_cmd_valid    = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          icache_cmd_ready = 1'b1;
          if (icache_cmd_valid) state_d = LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            icache_rsp_valid = 1'b1;
            icache_cmd_ready = 1'b1;
            state_d          = icache_cmd_valid ? LOOKUP : IDLE;
          end else begin
            state_d = REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          mem_cmd_valid = 1'b1;
          if (mem_cmd_ready) state_d = REFILL_DATA;
        end
        REFILL_DATA: begin
          if (mem_rsp_valid && last_beat) state_d = RESPOND;
        end
        RESPOND: begin
          icache_rsp_valid = 1'b1;
          state_d          = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == REFILL_REQ) beat_q <= '0;
      else if (beat_fire)        beat_q <= beat_q + 1'b1;
      // A flush seen while a refill is in flight keeps that line from becoming valid.
      if (state_q == RESPOND)
        flush_pend_q <= 1'b0;
      else if (icache_flush && (state_q == REFILL_REQ || state_q == REFILL_DATA))
        flush_pend_q <= 1'b1;
      if (icache_flush) valid_q <= '0;
      if (beat_fire && last_beat) valid_q[req_idx] <= !(flush_pend_q || icache_flush);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_fire) req_addr_q <= icache_cmd_payload_addr;
    if (beat_fire) data_q[req_idx][beat_q] <= mem_rsp_payload_data;
    if (beat_fire && last_beat) tag_q[req_idx] <= req_tag;
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      else     perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule
